// File: rtl/disp_pkg.sv
// Shared constants, frame bundle and digit-slice helper
// for the four-digit display scan controller.
package disp_pkg;

  localparam int DIGITS = 4;
  localparam int HEX_W  = 4;
  localparam logic [DIGITS-1:0] AN_OFF = '1;

  typedef logic [$clog2(DIGITS)-1:0] idx_t;

  typedef struct packed {
    logic [DIGITS*HEX_W-1:0] hexs;
    logic [DIGITS-1:0]       pts;
    logic [DIGITS-1:0]       les;
  } frame_t;

  function automatic logic [HEX_W-1:0] hex_at(
    input logic [DIGITS*HEX_W-1:0] h,
    input idx_t                    i
  );
    hex_at = h[i*HEX_W +: HEX_W];
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Digit-slot prescaler: counts 0..DIV_MAX-1 while enabled
// and flags the last count of each slot.
module scan_tick_gen #(
  parameter int unsigned DIV_MAX = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(DIV_MAX);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          last;

  always_comb begin
    last  = (cnt_q == CW'(DIV_MAX - 1));
    tick  = en && last;
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed 4-digit scan controller feeding an external
// hex decoder; double-buffered so frames never tear.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned DIV_MAX = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] hexs,
  input  logic [3:0]  points,
  input  logic [3:0]  les,
  output logic [3:0]  AN,
  output logic [3:0]  D,
  output logic        LE,
  output logic        point,
  output logic        frame_done
);

  logic   tick;
  logic   boundary;
  frame_t load_frame;

  idx_t   idx_q,     idx_d;
  frame_t stage_q,   stage_d;
  frame_t active_q,  active_d;
  logic   pending_q, pending_d;

  logic [3:0] an_q,    an_d;
  logic [3:0] dig_q,   dig_d;
  logic       le_q,    le_d;
  logic       point_q, point_d;
  logic       fd_q,    fd_d;

  scan_tick_gen #(
    .DIV_MAX (DIV_MAX)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick)
  );

  always_comb begin
    load_frame = '{hexs: hexs, pts: points, les: les};
    boundary   = tick && (idx_q == idx_t'(DIGITS - 1));
    idx_d      = tick ? idx_q + 1'b1 : idx_q;
    stage_d    = load ? load_frame : stage_q;
    active_d   = active_q;
    pending_d  = pending_q || load;
    // A load landing on the boundary bypasses staging.
    if (boundary) begin
      if (load) begin
        active_d  = load_frame;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = stage_q;
        pending_d = 1'b0;
      end
    end
  end

  always_comb begin
    an_d    = en ? ~(4'b0001 << idx_q) : AN_OFF;
    dig_d   = hex_at(active_q.hexs, idx_q);
    point_d = active_q.pts[idx_q];
    le_d    = en ? active_q.les[idx_q] : 1'b1;
    fd_d    = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      stage_q   <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      stage_q   <= stage_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q    <= AN_OFF;
      dig_q   <= '0;
      le_q    <= 1'b1;
      point_q <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      an_q    <= an_d;
      dig_q   <= dig_d;
      le_q    <= le_d;
      point_q <= point_d;
      fd_q    <= fd_d;
    end
  end

  assign AN         = an_q;
  assign D          = dig_q;
  assign LE         = le_q;
  assign point      = point_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with DIV_MAX=4
// (4 clocks per digit, 16 per frame).
module tb_disp_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] hexs;
  logic [3:0]  points;
  logic [3:0]  les;
  logic [3:0]  AN;
  logic [3:0]  D;
  logic        LE;
  logic        point;
  logic        frame_done;

  int npass;
  int ntotal;

  disp_scan_ctrl #(
    .DIV_MAX (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .hexs       (hexs),
    .points     (points),
    .les        (les),
    .AN         (AN),
    .D          (D),
    .LE         (LE),
    .point      (point),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // One full frame; up to two single-cycle loads at cycles ca/cb.
  task automatic run_frame(
    input string       tag,
    input logic [15:0] ed,
    input logic [3:0]  ep,
    input logic [3:0]  el,
    input int          ca,
    input logic [23:0] va,
    input int          cb,
    input logic [23:0] vb
  );
    for (int c = 1; c <= 16; c++) begin
      int         i;
      logic [3:0] ean;
      logic [3:0] ed_i;
      i    = (c - 1) / 4;
      ean  = 4'b1111 ^ (4'b0001 << i);
      ed_i = ed[4*i +: 4];
      load = (c == ca) || (c == cb);
      {hexs, points, les} = (c == cb) ? vb : va;
      cyc();
      load = 1'b0;
      chk($sformatf("%s.an%0d", tag, c), 16'(AN), 16'(ean));
      chk($sformatf("%s.d%0d", tag, c), 16'(D), 16'(ed_i));
      chk($sformatf("%s.pt%0d", tag, c), 16'(point), 16'(ep[i]));
      chk($sformatf("%s.le%0d", tag, c), 16'(LE), 16'(el[i]));
      chk($sformatf("%s.fd%0d", tag, c), 16'(frame_done),
          16'(c == 16));
    end
  endtask

  initial begin
    npass  = 0;
    ntotal = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    load   = 1'b0;
    hexs   = '0;
    points = '0;
    les    = '0;

    repeat (3) cyc();
    chk("rst.an", 16'(AN), 16'hF);
    chk("rst.d", 16'(D), 16'h0);
    chk("rst.le", 16'(LE), 16'h1);
    chk("rst.pt", 16'(point), 16'h0);
    chk("rst.fd", 16'(frame_done), 16'h0);
    rst_n = 1'b1;
    en    = 1'b1;

    run_frame("f1", 16'h0000, 4'b0000, 4'b0000, 0, '0, 0, '0);
    run_frame("f2", 16'h0000, 4'b0000, 4'b0000,
              5, {16'h4321, 4'b0101, 4'b0000}, 0, '0);
    run_frame("f3", 16'h4321, 4'b0101, 4'b0000, 0, '0, 0, '0);
    run_frame("f4", 16'h4321, 4'b0101, 4'b0000,
              3, {16'hAAAA, 4'b0000, 4'b0000},
              10, {16'h5555, 4'b0000, 4'b0000});
    run_frame("f5", 16'h5555, 4'b0000, 4'b0000,
              0, '0, 16, {16'hBEEF, 4'b0000, 4'b0000});
    chk("f5.pending", 16'(dut.pending_q), 16'h0);
    run_frame("f6", 16'hBEEF, 4'b0000, 4'b0000,
              8, {16'h1234, 4'b0000, 4'b1010}, 0, '0);
    run_frame("f7", 16'h1234, 4'b0000, 4'b1010, 0, '0, 0, '0);

    // Pause scanning one cycle into digit 2.
    repeat (9) cyc();
    chk("pz.an_pre", 16'(AN), 16'hB);
    chk("pz.d_pre", 16'(D), 16'h2);
    chk("pz.le_pre", 16'(LE), 16'h0);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      load = (k == 4);
      {hexs, points, les} = {16'h9876, 4'b0000, 4'b0000};
      cyc();
      load = 1'b0;
      chk($sformatf("pz.an_off%0d", k), 16'(AN), 16'hF);
      chk($sformatf("pz.le_off%0d", k), 16'(LE), 16'h1);
      chk($sformatf("pz.fd_off%0d", k), 16'(frame_done), 16'h0);
    end
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("pz.an_rem%0d", k), 16'(AN), 16'hB);
      chk($sformatf("pz.d_rem%0d", k), 16'(D), 16'h2);
      chk($sformatf("pz.fd_rem%0d", k), 16'(frame_done), 16'h0);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("pz.an_d3_%0d", k), 16'(AN), 16'h7);
      chk($sformatf("pz.d_d3_%0d", k), 16'(D), 16'h1);
      chk($sformatf("pz.le_d3_%0d", k), 16'(LE), 16'h1);
      chk($sformatf("pz.fd_d3_%0d", k), 16'(frame_done),
          16'(k == 3));
    end

    run_frame("f8", 16'h9876, 4'b0000, 4'b0000, 0, '0, 0, '0);

    // Reset mid-frame with a load still pending.
    load = 1'b1;
    {hexs, points, les} = {16'hCAFE, 4'b1111, 4'b0000};
    cyc();
    load = 1'b0;
    repeat (4) cyc();
    chk("ar.pending_pre", 16'(dut.pending_q), 16'h1);
    chk("ar.d_pre", 16'(D), 16'h7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.an", 16'(AN), 16'hF);
    chk("ar.d", 16'(D), 16'h0);
    chk("ar.le", 16'(LE), 16'h1);
    chk("ar.pt", 16'(point), 16'h0);
    chk("ar.fd", 16'(frame_done), 16'h0);
    chk("ar.pending", 16'(dut.pending_q), 16'h0);
    repeat (2) cyc();
    rst_n = 1'b1;
    run_frame("f9", 16'h0000, 4'b0000, 4'b0000, 0, '0, 0, '0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter DIV_MAX, default 50000: clk cycles per digit slot; legal range 2..2^20.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 en  input  1  scan enable; low blanks all digits and freezes scan state.
REQ-005 load  input  1  single-cycle strobe; captures hexs/points/les into the staging buffer.
REQ-006 hexs  input  16  four 4-bit hex codes; digit k = hexs[4k+3:4k].
REQ-007 points  input  4  decimal point per digit, active-high.
REQ-008 les  input  4  per-digit blank request, active-high.
REQ-009 AN  output  4  digit anodes, active-low one-hot.
REQ-010 D  output  4  hex code to the shared MC14495 decoder {D3,D2,D1,D0}.
REQ-011 LE  output  1  decoder blank; 1 = segments off.
REQ-012 point  output  1  decimal point to the decoder.
REQ-013 frame_done  output  1  one-cycle pulse at the end of each 4-digit frame.

Function
REQ-014 Prescaler SHALL count 0..DIV_MAX-1 while en=1, wrap to 0, and assert internal tick when the count equals DIV_MAX-1.
REQ-015 On tick, digit index idx (2 bits) SHALL increment, wrapping 3->0.
REQ-016 A frame boundary SHALL be a tick with idx=3; frame_done SHALL be high for exactly the following cycle.
REQ-017 load SHALL write the staging buffer and set pending; a later load before the boundary SHALL overwrite staging.
REQ-018 At a frame boundary with pending=1, the active buffer SHALL take staging and pending SHALL clear.
REQ-019 If load and a boundary occur in the same cycle, the active buffer SHALL take the load-cycle inputs directly and pending SHALL end cleared.
REQ-020 The active buffer SHALL change only at frame boundaries; no digit shows mixed old/new data within a frame.
REQ-021 Outputs SHALL be registered with one-cycle latency:
- AN = ~(1<<idx)
- D = active hex[idx]
- point = active points[idx]
- LE = active les[idx]
REQ-022 While en=0:
- prescaler, idx and active buffer hold
- AN=4'b1111, LE=1, frame_done=0
- load still captures into staging
REQ-023 When en returns to 1, scanning SHALL resume from the held prescaler count and idx.

Reset
REQ-024 rst_n low SHALL immediately clear prescaler, idx, staging, active and pending to 0 and force AN=4'b1111, D=0, LE=1, point=0, frame_done=0.
REQ-025 Reset asserted mid-frame SHALL discard pending data; no frame_done is issued for the aborted frame.
REQ-026 On the first rising edge after rst_n deasserts with en=1, AN SHALL become 4'b1110 and D SHALL become 0.

Structure
REQ-027 Shared package disp_pkg SHALL hold DIGITS=4, AN_OFF=4'b1111 and the digit-slice helper width constant HEX_W=4.
REQ-028 The prescaler SHALL be a separate sub-module, scan_tick_gen (parameter DIV_MAX; ports clk, rst_n, en, tick).
REQ-029 The decoder is not instantiated inside; D/LE/point connect externally to MyMC14495.

Verification (DIV_MAX=4)
REQ-030 Reset, en=1, no load -> AN sequence 1110,1101,1011,0111 every 4 cycles; D=0, LE=0; frame_done pulses every 16 cycles.
REQ-031 load with hexs=16'h4321, points=4'b0101, les=0 mid-frame -> D stays 0 until frame_done, then D=1,2,3,4 with point=1,0,1,0.
REQ-032 load 16'hAAAA then 16'h5555 in the same frame -> next frame shows only 5s; A never appears.
REQ-033 load 16'hBEEF coincident with the boundary tick -> the very next frame shows F,E,E,B and pending reads 0.
REQ-034 en=0 for 10 cycles mid-digit 2 -> AN=1111 and LE=1 throughout; after en=1, digit 2 completes its remaining slot cycles and then idx advances to 3.
REQ-035 rst_n pulsed low mid-frame with a pending load -> outputs reach reset values asynchronously; the post-reset frame shows zeros.
